// File: rtl/fir_core_pkg.sv
// Shared types and constants for the FIR core write-domain front end.
package fir_core_pkg;

   localparam int SAMPLE_W_DEF = 16;

   typedef enum logic {
      HUNT  = 1'b0,
      SHIFT = 1'b1
   } des_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_PEND = 2'd1,
      W_GAP  = 2'd2
   } wr_state_t;

endpackage

// File: rtl/fir_shift_in.sv
// Serial-to-parallel shifter: frame-aligned bit capture, emits a word and a
// same-cycle word_done strobe on the completing capture.
module fir_shift_in
   import fir_core_pkg::*;
#(
   parameter int DATA_W    = SAMPLE_W_DEF,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk1,
   input  logic              wr_rstn,
   input  logic              sdi,
   input  logic              sdi_valid,
   input  logic              sdi_frame,
   output logic [DATA_W-1:0] word,
   output logic              word_done,
   output logic              shifting
);

   localparam int               CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   des_state_t        state_d, state_q;
   logic [CNT_W-1:0]  bit_cnt_d, bit_cnt_q;
   logic [DATA_W-1:0] sh_d, sh_q;

   function automatic logic [DATA_W-1:0] shift_bit(input logic [DATA_W-1:0] cur,
                                                   input logic              b);
      if (MSB_FIRST) begin
         return {cur[DATA_W-2:0], b};
      end else begin
         return {b, cur[DATA_W-1:1]};
      end
   endfunction

   // A frame bit always restarts the word, even mid-word; the partial word is lost.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sh_d      = sh_q;
      word_done = 1'b0;
      if (sdi_valid) begin
         if (sdi_frame) begin
            sh_d      = shift_bit('0, sdi);
            bit_cnt_d = CNT_W'(1);
            state_d   = SHIFT;
         end else if (state_q == SHIFT) begin
            sh_d = shift_bit(sh_q, sdi);
            if (bit_cnt_q == LAST_CNT) begin
               bit_cnt_d = '0;
               state_d   = HUNT;
               word_done = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk1 or negedge wr_rstn) begin
      if (!wr_rstn) begin
         state_q   <= HUNT;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // Datapath only; a frame bit seeds from zero so no stale bits survive.
   always_ff @(posedge clk1) begin
      sh_q <= sh_d;
   end

   assign word     = sh_d;
   assign shifting = (state_q == SHIFT);

endmodule

// File: rtl/fir_sample_deser.sv
// FIR write-domain front end: deserializer, one-word holding register and FIFO
// writer with overflow flag. Optional drop counter under FIR_IN_DROP_CNT_EN.
module fir_sample_deser
   import fir_core_pkg::*;
#(
   parameter int DATA_W    = SAMPLE_W_DEF,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk1,
   input  logic              wr_rstn,
   input  logic              sdi,
   input  logic              sdi_valid,
   input  logic              sdi_frame,
   input  logic              fifo_full,
   output logic              wr_en,
   output logic [DATA_W-1:0] wr_data,
   output logic              overflow,
   input  logic              ovf_clr,
   output logic              busy
`ifdef FIR_IN_DROP_CNT_EN
   ,
   output logic [7:0]        drop_cnt
`endif
);

   logic [DATA_W-1:0] word;
   logic              word_done;
   logic              shifting;

   fir_shift_in #(
      .DATA_W    (DATA_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift_in (
      .clk1      (clk1),
      .wr_rstn   (wr_rstn),
      .sdi       (sdi),
      .sdi_valid (sdi_valid),
      .sdi_frame (sdi_frame),
      .word      (word),
      .word_done (word_done),
      .shifting  (shifting)
   );

   wr_state_t         wst_d, wst_q;
   logic              hold_vld_d, hold_vld_q;
   logic [DATA_W-1:0] hold_d, hold_q;
   logic              wr_en_d, wr_en_q;
   logic [DATA_W-1:0] wr_data_d, wr_data_q;
   logic              overflow_d, overflow_q;
   logic              drain;
   logic              accept;
   logic              drop;

   // A hold that drains at this edge frees the slot for a word completing at the same edge.
   assign drain  = (wst_q == W_PEND) && hold_vld_q && !fifo_full;
   assign accept = word_done && (!hold_vld_q || drain);
   assign drop   = word_done && hold_vld_q && !drain;

   always_comb begin
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      if (accept) begin
         hold_d     = word;
         hold_vld_d = 1'b1;
      end else if (drain) begin
         hold_vld_d = 1'b0;
      end
   end

   // W_GAP gives the registered full flag one cycle to account for the last write.
   always_comb begin
      wst_d     = wst_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      case (wst_q)
         W_IDLE: begin
            if (hold_vld_d) begin
               wst_d = W_PEND;
            end
         end
         W_PEND: begin
            if (drain) begin
               wr_en_d   = 1'b1;
               wr_data_d = hold_q;
               wst_d     = W_GAP;
            end
         end
         W_GAP: begin
            wst_d = hold_vld_d ? W_PEND : W_IDLE;
         end
         default: begin
            wst_d = W_IDLE;
         end
      endcase
   end

   always_comb begin
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk1 or negedge wr_rstn) begin
      if (!wr_rstn) begin
         wst_q      <= W_IDLE;
         hold_vld_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         wst_q      <= wst_d;
         hold_vld_q <= hold_vld_d;
         wr_en_q    <= wr_en_d;
         wr_data_q  <= wr_data_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk1) begin
      hold_q <= hold_d;
   end

`ifdef FIR_IN_DROP_CNT_EN
   logic [7:0] drop_cnt_d, drop_cnt_q;

   // Clear and drop together leave exactly one counted drop.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (ovf_clr) begin
         drop_cnt_d = drop ? 8'd1 : 8'd0;
      end else if (drop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk1 or negedge wr_rstn) begin
      if (!wr_rstn) begin
         drop_cnt_q <= 8'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

   assign wr_en    = wr_en_q;
   assign wr_data  = wr_data_q;
   assign overflow = overflow_q;
   assign busy     = shifting || hold_vld_q || (wst_q == W_GAP);

endmodule

// File: tb/tb_fir_sample_deser.sv
// Directed bench for fir_sample_deser (DATA_W=16, MSB first) with a write monitor
// and a small lagging-full FIFO model.
module tb_fir_sample_deser;

   logic        clk1 = 1'b0;
   logic        wr_rstn;
   logic        sdi, sdi_valid, sdi_frame;
   logic        fifo_full;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        overflow;
   logic        ovf_clr;
   logic        busy;
`ifdef FIR_IN_DROP_CNT_EN
   logic [7:0]  drop_cnt;
`endif

   fir_sample_deser #(.DATA_W(16), .MSB_FIRST(1'b1)) dut (
      .clk1      (clk1),
      .wr_rstn   (wr_rstn),
      .sdi       (sdi),
      .sdi_valid (sdi_valid),
      .sdi_frame (sdi_frame),
      .fifo_full (fifo_full),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr),
      .busy      (busy)
`ifdef FIR_IN_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   always #5 clk1 = ~clk1;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // FIFO full source: manual level or a depth-1 model whose flag lags a write by one edge.
   logic       full_man;
   logic       mdl_en;
   logic       full_mdl;
   logic [3:0] occ;
   logic [2:0] rd_div;
   logic       rd_mdl;
   logic [3:0] occ_nxt;

   assign fifo_full = mdl_en ? full_mdl : full_man;
   assign rd_mdl    = (rd_div == 3'd4) && (occ != 4'd0);
   assign occ_nxt   = occ + {3'd0, wr_en} - {3'd0, rd_mdl};

   always @(posedge clk1) begin
      if (!mdl_en) begin
         occ      <= 4'd0;
         full_mdl <= 1'b0;
         rd_div   <= 3'd0;
      end else begin
         occ      <= occ_nxt;
         full_mdl <= (occ_nxt >= 4'd1);
         rd_div   <= (rd_div == 3'd4) ? 3'd0 : rd_div + 3'd1;
      end
   end

   // Write monitor: logs every written word and checks write spacing and full handling.
   logic [15:0] wr_q[$];
   logic        wr_en_prev = 1'b0;
   logic        full_at_edge = 1'b0;

   always @(posedge clk1) full_at_edge <= fifo_full;

   always @(negedge clk1) begin
      if (wr_rstn === 1'b1) begin
         if (wr_en) begin
            chk("wr_no_b2b", {31'd0, wr_en_prev}, 32'd0);
            chk("wr_not_full", {31'd0, full_at_edge}, 32'd0);
            wr_q.push_back(wr_data);
         end
         wr_en_prev <= wr_en;
      end
   end

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic expect_wr(input string tag, input logic [15:0] exp);
      logic [31:0] got;
      if (wr_q.size() > 0) got = {16'd0, wr_q.pop_front()};
      else                 got = 'x;
      chk(tag, got, {16'd0, exp});
   endtask

   task automatic send_word(input logic [15:0] w, input int nbits, input bit gaps,
                            input bit clr_last, input bit unfull_last);
      int g;
      for (int i = 0; i < nbits; i++) begin
         if (gaps) begin
            g = int'($urandom_range(0, 2));
            repeat (g) begin
               sdi_valid = 1'b0;
               sdi_frame = 1'($urandom);
               sdi       = 1'($urandom);
               tick();
            end
         end
         sdi_valid = 1'b1;
         sdi_frame = (i == 0);
         sdi       = w[15-i];
         if (i == nbits - 1) begin
            if (clr_last)    ovf_clr  = 1'b1;
            if (unfull_last) full_man = 1'b0;
         end
         tick();
      end
      sdi_valid = 1'b0;
      sdi_frame = 1'b0;
      ovf_clr   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      wr_rstn   = 1'b0;
      sdi       = 1'b0;
      sdi_valid = 1'b0;
      sdi_frame = 1'b0;
      full_man  = 1'b0;
      mdl_en    = 1'b0;
      ovf_clr   = 1'b0;

      // Reset with random serial activity
      repeat (10) begin
         sdi       = 1'($urandom);
         sdi_valid = 1'($urandom);
         sdi_frame = 1'($urandom);
         tick();
      end
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef FIR_IN_DROP_CNT_EN
      chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
`endif
      sdi_valid = 1'b0;
      sdi_frame = 1'b0;
      wr_rstn   = 1'b1;
      tick();
      tick();

      // Single word and write latency
      send_word(16'hA5C3, 16, 1'b0, 1'b0, 1'b0);
      chk("t2_lat_n_wr_en", {31'd0, wr_en}, 32'd0);
      chk("t2_lat_n_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("t2_lat_n1_wr_en", {31'd0, wr_en}, 32'd1);
      chk("t2_lat_n1_data", {16'd0, wr_data}, 32'h0000A5C3);
      chk("t2_gap_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("t2_pulse_end", {31'd0, wr_en}, 32'd0);
      chk("t2_idle_busy", {31'd0, busy}, 32'd0);
      chk("t2_count", wr_q.size(), 32'd1);
      expect_wr("t2_word", 16'hA5C3);

      // Partial word then resync with gapped valids
      send_word(16'hFFFF, 7, 1'b0, 1'b0, 1'b0);
      chk("t3_partial_busy", {31'd0, busy}, 32'd1);
      send_word(16'h1234, 16, 1'b1, 1'b0, 1'b0);
      repeat (5) tick();
      chk("t3_count", wr_q.size(), 32'd1);
      expect_wr("t3_word", 16'h1234);
      chk("t3_overflow", {31'd0, overflow}, 32'd0);

      // Full stall: second word dropped, first written after release
      full_man = 1'b1;
      send_word(16'h0001, 16, 1'b0, 1'b0, 1'b0);
      send_word(16'h0002, 16, 1'b0, 1'b0, 1'b0);
      chk("t4_overflow", {31'd0, overflow}, 32'd1);
`ifdef FIR_IN_DROP_CNT_EN
      chk("t4_drop_cnt", {24'd0, drop_cnt}, 32'd1);
`endif
      repeat (4) tick();
      chk("t4_stalled", wr_q.size(), 32'd0);
      chk("t4_busy", {31'd0, busy}, 32'd1);
      full_man = 1'b0;
      repeat (5) tick();
      chk("t4_count", wr_q.size(), 32'd1);
      expect_wr("t4_word", 16'h0001);
      chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("t4_ovf_clr", {31'd0, overflow}, 32'd0);
`ifdef FIR_IN_DROP_CNT_EN
      chk("t4_cnt_clr", {24'd0, drop_cnt}, 32'd0);
`endif

      // Word completes on the same edge the hold register drains
      full_man = 1'b1;
      send_word(16'h00AA, 16, 1'b0, 1'b0, 1'b0);
      send_word(16'h00BB, 16, 1'b0, 1'b0, 1'b1);
      chk("t4b_no_drop", {31'd0, overflow}, 32'd0);
      repeat (6) tick();
      chk("t4b_count", wr_q.size(), 32'd2);
      expect_wr("t4b_first", 16'h00AA);
      expect_wr("t4b_second", 16'h00BB);

      // Back-to-back words into a FIFO whose full flag lags each write
      mdl_en = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         send_word(16'h1111 * k[15:0], 16, 1'b0, 1'b0, 1'b0);
      end
      repeat (12) tick();
      chk("t5_count", wr_q.size(), 32'd6);
      for (int k = 1; k <= 6; k++) begin
         expect_wr("t5_word", 16'h1111 * k[15:0]);
      end
      chk("t5_overflow", {31'd0, overflow}, 32'd0);
      mdl_en   = 1'b0;
      full_man = 1'b0;
      tick();

      // Clear coinciding with a drop: set wins
      full_man = 1'b1;
      send_word(16'h0C0C, 16, 1'b0, 1'b0, 1'b0);
      send_word(16'h0D0D, 16, 1'b0, 1'b1, 1'b0);
      chk("t6_set_wins", {31'd0, overflow}, 32'd1);
`ifdef FIR_IN_DROP_CNT_EN
      chk("t6_cnt_one", {24'd0, drop_cnt}, 32'd1);
`endif
      tick();
      chk("t6_ovf_hold", {31'd0, overflow}, 32'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("t6_clr_alone", {31'd0, overflow}, 32'd0);
      full_man = 1'b0;
      repeat (5) tick();
      chk("t6_count", wr_q.size(), 32'd1);
      expect_wr("t6_word", 16'h0C0C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fir_sample_deser.md
Name: fir_sample_deser

Overview:
Write-domain front end of the FIR core. It deserializes the incoming serial sample stream into DATA_W-bit words and pushes each word into the dual-clock sample FIFO (write side), honouring that FIFO's registered full flag. A one-word holding register absorbs short FIFO-full stalls. Words that arrive while the holding register is still occupied are dropped and flagged.

Parameters:
DATA_W, 16, sample word width; equals the FIFO data width.
MSB_FIRST, 1, 1 = first serial bit is the word MSB; 0 = LSB first.

Ports:
clk1  input  1  write-domain clock; same clock as the FIFO write side.
wr_rstn  input  1  asynchronous, active-low reset.
sdi  input  1  serial sample data bit.
sdi_valid  input  1  sdi is valid this cycle.
sdi_frame  input  1  qualified by sdi_valid; marks bit 0 of a new word.
fifo_full  input  1  registered full flag from the FIFO write side.
wr_en  output  1  FIFO write strobe; registered; one-cycle pulses.
wr_data  output  DATA_W  FIFO write data; registered; valid while wr_en is high.
overflow  output  1  sticky flag: a completed word was dropped.
ovf_clr  input  1  synchronous clear of overflow.
busy  output  1  high when a word is partially shifted or the holding register is occupied.

Behaviour:
- Reset (wr_rstn low, asynchronous): all outputs are 0. Deserializer FSM goes to HUNT, writer FSM goes to W_IDLE, bit_cnt = 0, hold_vld = 0.
- Deserializer FSM:
  - HUNT: ignores sdi_valid bits without sdi_frame. sdi_valid && sdi_frame captures the bit, sets bit_cnt = 1 and moves to SHIFT.
  - SHIFT: each sdi_valid captures one bit and increments bit_cnt. Cycles without sdi_valid hold state.
  - sdi_frame asserted mid-word restarts the word: the partial word is discarded silently and bit_cnt = 1.
  - The capture with bit_cnt == DATA_W-1 completes the word and returns to HUNT. The next word again requires sdi_frame.
  - Bit order: with MSB_FIRST=1 the shift register shifts left and the new bit enters at the LSB. With MSB_FIRST=0 it shifts right and the new bit enters at the MSB.
- Holding register: a completed word loads hold and sets hold_vld at the completing edge.
- Writer FSM:
  - W_IDLE: moves to W_PEND when hold_vld is set.
  - W_PEND: if fifo_full is 0, the next edge sets wr_en=1 and wr_data=hold, clears hold_vld and moves to W_GAP. If fifo_full is 1, it waits with no timeout.
  - W_GAP: wr_en=0 for exactly one cycle so that fifo_full can reflect the write just made. Then moves to W_PEND if hold_vld is set, else W_IDLE.
  - wr_en is never high in two consecutive cycles.
- Latency: the last serial bit is captured at edge N, hold_vld is set at N, and wr_en rises at edge N+1 when the FIFO is not full.
- Simultaneous events:
  - Word completes at the same edge that the holding register drains (W_PEND→W_GAP): the new word is accepted into hold, with no drop.
  - Word completes while hold_vld is set and not draining: the new word is discarded, hold keeps the old word, and overflow is set.
  - ovf_clr together with a new drop: the set wins.
- busy = (deserializer state == SHIFT) || hold_vld || (writer state == W_GAP).

Optional Feature:
FIR_IN_DROP_CNT_EN:
- Defined: adds output drop_cnt [7:0]. It increments on each dropped word, saturates at 255, resets to 0, and is cleared by ovf_clr. If a drop and ovf_clr occur together, the result is 1.
- Undefined: the port and its counter are absent. The overflow behaviour is unchanged.

Decomposition:
- Shared package fir_core_pkg holds:
  - the deserializer state encoding: HUNT=1'b0, SHIFT=1'b1;
  - the writer state encoding: W_IDLE=2'd0, W_PEND=2'd1, W_GAP=2'd2;
  - the default sample width constant, 16.
- One natural sub-module: fir_shift_in, which holds the shift register, bit counter and frame logic and emits word plus word_done. The writer FSM and overflow logic stay in the top.

Test Plan:
1. Reset check: hold wr_rstn low with random sdi activity → wr_en=0, wr_data=0, overflow=0, busy=0.
2. Single word, MSB_FIRST=1: frame and 16 valid bits of 0xA5C3, fifo_full=0 → one wr_en pulse with wr_data=0xA5C3, one cycle after the last bit.
3. Gapped valids plus mid-word resync: send 7 bits of 0xFFFF, then a new frame and 0x1234 with random sdi_valid gaps → only 0x1234 is written, overflow=0.
4. Full stall: with fifo_full=1, send 0x0001 then 0x0002 → 0x0002 is dropped and overflow=1 (drop_cnt=1 when enabled). Release full → exactly one write of 0x0001.
5. Full-with-lag scenario: fifo_full rises one cycle after a write while words arrive back-to-back → no wr_en while fifo_full=1, and at least one idle cycle between any two wr_en pulses.
6. Clear priority: ovf_clr pulse in the same cycle as a drop → overflow stays 1. Later ovf_clr alone → overflow=0.
